// File: rtl/eb_pkg.sv
// Shared definitions for the elastic-buffer family: one-hot occupancy
// encodings and the counter-width helper.
package eb_pkg;

    localparam int ST_W = 3;
    typedef logic [ST_W-1:0] eb_state_t;

    localparam eb_state_t S_EMPTY = 3'b001;
    localparam eb_state_t S_ONE   = 3'b010;
    localparam eb_state_t S_TWO   = 3'b100;

    // Width of a counter that walks 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eb_unpack_ctrl.sv
// Occupancy FSM and beat counter for eb_unpack; produces the handshake
// outputs and the load enables for the active (A) and pending (P) words.
module eb_unpack_ctrl
    import eb_pkg::*;
#(
    parameter  int RATIO = 4,
    localparam int CW    = cnt_width(RATIO)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          t_0_valid,
    input  logic          i_0_ready,
    output logic          t_0_ready,
    output logic          i_0_valid,
    output logic          i_0_eow,
    output logic [CW-1:0] cnt,
    output logic          a_load,
    output logic          a_from_p,
    output logic          p_load
);

    localparam logic [CW-1:0] CNT_MAX = CW'(RATIO - 1);

    eb_state_t     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          acc, beat, done;

    // Ready is a pure decode of state; reset forces it low immediately.
    assign t_0_ready = (state_reg != S_TWO) && !reset;
    assign i_0_valid = (state_reg == S_ONE) || (state_reg == S_TWO);
    assign i_0_eow   = i_0_valid && (cnt_reg == CNT_MAX);
    assign cnt       = cnt_reg;

    assign acc  = t_0_valid && t_0_ready;
    assign beat = i_0_valid && i_0_ready;
    assign done = beat && (cnt_reg == CNT_MAX);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_load     = 1'b0;
        a_from_p   = 1'b0;
        p_load     = 1'b0;
        if (beat) begin
            cnt_next = cnt_reg + CW'(1);
        end
        case (state_reg)
            S_EMPTY: begin
                if (acc) begin
                    a_load     = 1'b1;
                    cnt_next   = '0;
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (acc && !done) begin
                    p_load     = 1'b1;
                    state_next = S_TWO;
                end else if (acc && done) begin
                    // Refill A directly so the next word follows with no bubble.
                    a_load   = 1'b1;
                    cnt_next = '0;
                end else if (done) begin
                    state_next = S_EMPTY;
                end
            end
            S_TWO: begin
                if (done) begin
                    a_load     = 1'b1;
                    a_from_p   = 1'b1;
                    cnt_next   = '0;
                    state_next = S_ONE;
                end
            end
            default: begin
                state_next = S_EMPTY;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_EMPTY;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule

// File: rtl/eb_unpack.sv
// Wide-to-narrow stream downsizer: each accepted word leaves as RATIO beats,
// LSB slice first, with a pending slot so input ready never depends on i_0_ready.
module eb_unpack
    import eb_pkg::*;
#(
    parameter  int W_OUT = 8,
    parameter  int RATIO = 4,
    localparam int W_IN  = W_OUT * RATIO,
    localparam int CW    = cnt_width(RATIO)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_0_valid,
    output logic             t_0_ready,
    input  logic [W_IN-1:0]  t_0_data,
    input  logic             t_0_last,
    output logic             i_0_valid,
    input  logic             i_0_ready,
    output logic [W_OUT-1:0] i_0_data,
    output logic             i_0_eow,
    output logic             i_0_last
);

    logic [W_IN-1:0]  a_reg, p_reg;
    logic             a_last_reg, p_last_reg;
    logic [CW-1:0]    cnt;
    logic             a_load, a_from_p, p_load;
    logic [W_OUT-1:0] slice [RATIO];

    eb_unpack_ctrl #(
        .RATIO (RATIO)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .t_0_valid (t_0_valid),
        .i_0_ready (i_0_ready),
        .t_0_ready (t_0_ready),
        .i_0_valid (i_0_valid),
        .i_0_eow   (i_0_eow),
        .cnt       (cnt),
        .a_load    (a_load),
        .a_from_p  (a_from_p),
        .p_load    (p_load)
    );

    // Word storage is datapath only; occupancy lives in the controller.
    always_ff @(posedge clk) begin
        if (a_load) begin
            a_reg      <= a_from_p ? p_reg      : t_0_data;
            a_last_reg <= a_from_p ? p_last_reg : t_0_last;
        end
        if (p_load) begin
            p_reg      <= t_0_data;
            p_last_reg <= t_0_last;
        end
    end

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
        assign slice[gi] = a_reg[gi*W_OUT +: W_OUT];
    end

    assign i_0_data = slice[cnt];
    assign i_0_last = i_0_eow && a_last_reg;

endmodule

// File: tb/tb_eb_unpack.sv
// Directed bench for eb_unpack with a byte-order scoreboard and a
// hold-stability monitor running alongside the directed scenarios.
module tb_eb_unpack;

    localparam int W_OUT = 8;
    localparam int RATIO = 4;
    localparam int W_IN  = W_OUT * RATIO;

    logic             clk = 1'b0;
    logic             reset;
    logic             t_0_valid;
    logic             t_0_ready;
    logic [W_IN-1:0]  t_0_data;
    logic             t_0_last;
    logic             i_0_valid;
    logic             i_0_ready;
    logic [W_OUT-1:0] i_0_data;
    logic             i_0_eow;
    logic             i_0_last;

    always #5 clk = ~clk;

    eb_unpack #(
        .W_OUT (W_OUT),
        .RATIO (RATIO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .t_0_valid (t_0_valid),
        .t_0_ready (t_0_ready),
        .t_0_data  (t_0_data),
        .t_0_last  (t_0_last),
        .i_0_valid (i_0_valid),
        .i_0_ready (i_0_ready),
        .i_0_data  (i_0_data),
        .i_0_eow   (i_0_eow),
        .i_0_last  (i_0_last)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: {last, eow, byte} per expected beat.
    logic [9:0] exp_q [$];
    logic [9:0] exp_beat;
    int         n_words_in = 0;
    int         n_last_in  = 0;
    int         n_last_out = 0;
    bit         verbose    = 1'b1;
    bit         hold_reg   = 1'b0;
    logic [10:0] hold_val;

    always @(negedge clk) begin
        if (reset) begin
            hold_reg <= 1'b0;
        end else begin
            if (hold_reg) begin
                check("hold_stable", {21'd0, i_0_valid, i_0_eow, i_0_last, i_0_data}, {21'd0, hold_val});
            end
            hold_reg <= i_0_valid && !i_0_ready;
            hold_val <= {i_0_valid, i_0_eow, i_0_last, i_0_data};
            if (t_0_valid && t_0_ready) begin
                for (int k = 0; k < RATIO; k++) begin
                    exp_q.push_back({(k == RATIO-1) && t_0_last, k == RATIO-1, t_0_data[k*W_OUT +: W_OUT]});
                end
                n_words_in++;
                if (t_0_last) n_last_in++;
                if (verbose) $display("word %0d in: %08h last=%0b", n_words_in, t_0_data, t_0_last);
            end
            if (i_0_valid && i_0_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_qsize", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("sb_beat", {22'd0, i_0_last, i_0_eow, i_0_data}, {22'd0, exp_beat});
                end
                if (i_0_last) n_last_out++;
            end
        end
    end

    task automatic drain(input string tag);
        int guard;
        t_0_valid = 1'b0;
        i_0_ready = 1'b1;
        guard = 0;
        while ((i_0_valid || exp_q.size() != 0) && guard < 200) begin
            tick();
            guard++;
        end
        check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_idle"}, {31'd0, i_0_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  bytes1 [4];
        logic [31:0] word;
        int          run, low_run, max_low, guard, sent, base;
        bit          ended, acc_now;

        reset     = 1'b1;
        t_0_valid = 1'b0;
        t_0_data  = '0;
        t_0_last  = 1'b0;
        i_0_ready = 1'b0;
        repeat (3) tick();
        check("rst_t_ready", {31'd0, t_0_ready}, 32'd0);
        check("rst_i_valid", {31'd0, i_0_valid}, 32'd0);
        check("rst_eow",     {31'd0, i_0_eow},   32'd0);
        check("rst_last",    {31'd0, i_0_last},  32'd0);
        reset = 1'b0;
        #1;
        check("rel_t_ready", {31'd0, t_0_ready}, 32'd1);

        // Single word, LSB slice first.
        bytes1[0] = 8'h11; bytes1[1] = 8'h22; bytes1[2] = 8'h33; bytes1[3] = 8'h44;
        i_0_ready = 1'b1;
        t_0_valid = 1'b1;
        t_0_data  = 32'h44332211;
        t_0_last  = 1'b1;
        tick();
        t_0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("single_valid", {31'd0, i_0_valid}, 32'd1);
            check("single_data",  {24'd0, i_0_data},  {24'd0, bytes1[k]});
            check("single_eow",   {31'd0, i_0_eow},   {31'd0, k == 3});
            check("single_last",  {31'd0, i_0_last},  {31'd0, k == 3});
            tick();
        end
        check("single_after", {31'd0, i_0_valid}, 32'd0);
        drain("single");

        // Streaming: 8 words, contiguous 32 beats.
        sent = 0; run = 0; ended = 0; low_run = 0; max_low = 0; guard = 0;
        t_0_valid = 1'b1;
        t_0_data  = 32'h03020100;
        t_0_last  = 1'b0;
        while (!ended && guard < 80) begin
            if (i_0_valid) run++;
            else if (run > 0) ended = 1;
            if (t_0_ready) low_run = 0;
            else begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end
            acc_now = t_0_valid && t_0_ready;
            tick();
            guard++;
            if (acc_now) begin
                sent++;
                t_0_data = t_0_data + 32'h04040404;
                t_0_last = (sent == 7);
                if (sent == 8) t_0_valid = 1'b0;
            end
        end
        check("stream_run",     32'(run),     32'd32);
        check("stream_rdy_low", 32'(max_low), 32'd3);
        drain("stream");

        // Backpressure with t_0_valid held high throughout.
        base      = n_words_in;
        t_0_valid = 1'b1;
        t_0_data  = 32'h44332211;
        t_0_last  = 1'b0;
        tick();
        t_0_data  = 32'h88776655;
        tick();
        i_0_ready = 1'b0;
        t_0_data  = 32'hCCBBAA99;
        t_0_last  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_t_ready", {31'd0, t_0_ready}, 32'd0);
            check("bp_data",    {24'd0, i_0_data},  32'h22);
            tick();
        end
        check("bp_accepted", 32'(n_words_in - base), 32'd2);
        i_0_ready = 1'b1;
        guard = 0;
        while (!t_0_ready && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_reopen", {31'd0, t_0_ready}, 32'd1);
        tick();
        drain("bp");

        // Random valid/ready toggling over 1000 words.
        verbose = 1'b0;
        base    = n_words_in;
        sent    = 0;
        guard   = 0;
        t_0_valid = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            if (!t_0_valid && ($urandom_range(0, 3) != 0)) begin
                t_0_valid = 1'b1;
                t_0_data  = $urandom;
                t_0_last  = ($urandom_range(0, 2) == 0);
            end
            i_0_ready = ($urandom_range(0, 3) != 0);
            acc_now   = t_0_valid && t_0_ready;
            tick();
            guard++;
            if (acc_now) begin
                sent++;
                t_0_valid = 1'b0;
            end
        end
        check("rand_words", 32'(n_words_in - base), 32'd1000);
        drain("rand");
        check("rand_last_cnt", 32'(n_last_out), 32'(n_last_in));
        verbose = 1'b1;

        // Reset mid-word with P loaded.
        t_0_valid = 1'b1;
        t_0_data  = 32'h44332211;
        t_0_last  = 1'b0;
        tick();
        t_0_data  = 32'h88776655;
        tick();
        t_0_valid = 1'b0;
        tick();
        check("mid_data", {24'd0, i_0_data}, 32'h33);
        reset = 1'b1;
        #1;
        check("mid_t_ready", {31'd0, t_0_ready}, 32'd0);
        tick();
        check("mid_valid", {31'd0, i_0_valid}, 32'd0);
        tick();
        reset = 1'b0;
        exp_q.delete();
        t_0_valid = 1'b1;
        t_0_data  = 32'hDDCCBBAA;
        t_0_last  = 1'b1;
        tick();
        t_0_valid = 1'b0;
        check("mid_first",     {24'd0, i_0_data}, 32'hAA);
        check("mid_first_eow", {31'd0, i_0_eow},  32'd0);
        drain("mid");

        // Accept and done in the same cycle while in S_ONE.
        t_0_valid = 1'b1;
        t_0_data  = 32'h44332211;
        t_0_last  = 1'b0;
        tick();
        t_0_valid = 1'b0;
        repeat (3) tick();
        check("sim_eow",     {31'd0, i_0_eow},   32'd1);
        check("sim_rdy_pre", {31'd0, t_0_ready}, 32'd1);
        t_0_valid = 1'b1;
        t_0_data  = 32'h0D0C0B0A;
        t_0_last  = 1'b1;
        tick();
        t_0_valid = 1'b0;
        check("sim_valid", {31'd0, i_0_valid}, 32'd1);
        check("sim_data",  {24'd0, i_0_data},  32'h0A);
        check("sim_rdy",   {31'd0, t_0_ready}, 32'd1);
        tick();
        check("sim_data2", {24'd0, i_0_data},  32'h0B);
        drain("sim");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
